// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end: default widths, FSM encodings and opcodes.
package alu_pkg;

    localparam int unsigned NbitsDefault = 8;
    localparam int unsigned CodOpDefault = 6;

    // Loader FSM; encodings are visible on the LEDs, so they are fixed.
    typedef enum logic [2:0] {
        StEsperaA   = 3'd0,
        StEsperaB   = 3'd1,
        StEsperaOp  = 3'd2,
        StCaptura   = 3'd3,
        StResultado = 3'd4
    } estado_e;

    // ALU opcodes (MIPS-style funct field values).
    localparam logic [5:0] OpAdd = 6'b100000;
    localparam logic [5:0] OpSub = 6'b100010;
    localparam logic [5:0] OpAnd = 6'b100100;
    localparam logic [5:0] OpOr  = 6'b100101;
    localparam logic [5:0] OpXor = 6'b100110;
    localparam logic [5:0] OpSra = 6'b000011;
    localparam logic [5:0] OpSrl = 6'b000010;
    localparam logic [5:0] OpNor = 6'b100111;

endpackage

// File: rtl/btn_edge_sync.sv
// Button synchronizer followed by a rising-edge detector: one 1-cycle pulse per press.
// SYNC_STAGES must be at least 2.
module btn_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic btn_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_d, sync_q;
    logic                   level_q;

    // Shift the raw button into the synchronizer chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_i};
    end

    // Synchronizer and previous-level flops, synchronously cleared.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            sync_q  <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Pulse is derived only from flops, so it never depends on the raw input directly.
    assign pulse_o = sync_q[SYNC_STAGES-1] & ~level_q;

endmodule

// File: rtl/alu_input_loader.sv
// Loads ALU operands A, B and the opcode from switches under button control, then
// captures the ALU result into a held register. COD_OP must not exceed NBITS.
module alu_input_loader
    import alu_pkg::*;
#(
    parameter int unsigned NBITS       = NbitsDefault,
    parameter int unsigned COD_OP      = CodOpDefault,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NBITS-1:0]  i_switches,
    input  logic              i_btn_a,
    input  logic              i_btn_b,
    input  logic              i_btn_op,
    output logic [NBITS-1:0]  operando_A,
    output logic [NBITS-1:0]  operando_B,
    output logic [COD_OP-1:0] cod_operacion,
    input  logic [NBITS-1:0]  ALU_Result,
    output logic [NBITS-1:0]  o_result,
    output logic              o_result_valid,
    output logic [2:0]        o_estado
);

    logic pulse_a, pulse_b, pulse_op;

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .btn_i    (i_btn_a),
        .pulse_o  (pulse_a)
    );

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .btn_i    (i_btn_b),
        .pulse_o  (pulse_b)
    );

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_op (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .btn_i    (i_btn_op),
        .pulse_o  (pulse_op)
    );

    estado_e           state_q;
    logic [NBITS-1:0]  a_q, b_q, result_q;
    logic [COD_OP-1:0] op_q;
    logic              valid_q;

    // Loader FSM with all outputs registered; pulses not accepted by a state are dropped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StEsperaA;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StEsperaA: begin
                    if (pulse_a) begin
                        a_q     <= i_switches;
                        state_q <= StEsperaB;
                    end
                end
                StEsperaB: begin
                    if (pulse_b) begin
                        b_q     <= i_switches;
                        state_q <= StEsperaOp;
                    end
                end
                StEsperaOp: begin
                    if (pulse_op) begin
                        op_q    <= i_switches[COD_OP-1:0];
                        state_q <= StCaptura;
                    end
                end
                StCaptura: begin
                    // ALU has seen the new opcode for a full cycle by now.
                    result_q <= ALU_Result;
                    valid_q  <= 1'b1;
                    state_q  <= StResultado;
                end
                StResultado: begin
                    // A new A restarts the sequence and wins over an opcode reload.
                    if (pulse_a) begin
                        a_q     <= i_switches;
                        valid_q <= 1'b0;
                        state_q <= StEsperaB;
                    end else if (pulse_op) begin
                        op_q    <= i_switches[COD_OP-1:0];
                        state_q <= StCaptura;
                    end
                end
                default: state_q <= StEsperaA;
            endcase
        end
    end

    assign operando_A     = a_q;
    assign operando_B     = b_q;
    assign cod_operacion  = op_q;
    assign o_result       = result_q;
    assign o_result_valid = valid_q;
    assign o_estado       = state_q;

endmodule

// File: tb/tb_alu_input_loader.sv
// Directed bench for alu_input_loader with a small behavioural ALU closing the loop.
module tb_alu_input_loader;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] i_switches;
    logic       i_btn_a, i_btn_b, i_btn_op;
    logic [7:0] operando_A, operando_B, ALU_Result, o_result;
    logic [5:0] cod_operacion;
    logic       o_result_valid;
    logic [2:0] o_estado;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu_input_loader #(.NBITS(8), .COD_OP(6), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_switches     (i_switches),
        .i_btn_a        (i_btn_a),
        .i_btn_b        (i_btn_b),
        .i_btn_op       (i_btn_op),
        .operando_A     (operando_A),
        .operando_B     (operando_B),
        .cod_operacion  (cod_operacion),
        .ALU_Result     (ALU_Result),
        .o_result       (o_result),
        .o_result_valid (o_result_valid),
        .o_estado       (o_estado)
    );

    // Combinational ALU model driven by the DUT's registered operands.
    always_comb begin
        ALU_Result = 8'h00;
        case (cod_operacion)
            OpAdd:   ALU_Result = operando_A + operando_B;
            OpSub:   ALU_Result = operando_A - operando_B;
            OpAnd:   ALU_Result = operando_A & operando_B;
            OpOr:    ALU_Result = operando_A | operando_B;
            OpXor:   ALU_Result = operando_A ^ operando_B;
            OpSra:   ALU_Result = $signed(operando_A) >>> operando_B;
            OpSrl:   ALU_Result = operando_A >> operando_B;
            OpNor:   ALU_Result = ~(operando_A | operando_B);
            default: ALU_Result = 8'h00;
        endcase
    end

    // Press: raise at a negedge, hold over three edges, release and let the chain drain.
    task automatic press(input bit a, input bit b, input bit op, input logic [7:0] sw);
        @(negedge clk);
        i_switches = sw;
        i_btn_a = a; i_btn_b = b; i_btn_op = op;
        repeat (3) @(negedge clk);
        i_btn_a = 1'b0; i_btn_b = 1'b0; i_btn_op = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({operando_A, operando_B, cod_operacion, o_result, o_result_valid, o_estado} !== 34'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got A=%h B=%h op=%b res=%h v=%b st=%0d, want all 0",
                     operando_A, operando_B, cod_operacion, o_result, o_result_valid, o_estado);
        end
    endtask

    task automatic test_basic_add();
        press(1, 0, 0, 8'h04);
        tests_run++;
        if (operando_A !== 8'h04 || o_estado !== 3'd1) begin
            tests_failed++;
            $display("FAIL load_a: got A=%h st=%0d, want A=04 st=1", operando_A, o_estado);
        end
        press(0, 1, 0, 8'h0C);
        tests_run++;
        if (operando_B !== 8'h0C || o_estado !== 3'd2) begin
            tests_failed++;
            $display("FAIL load_b: got B=%h st=%0d, want B=0c st=2", operando_B, o_estado);
        end
        // Traced opcode load: raw sampled at edge t, pulse after t+1, load at t+2, capture t+3.
        @(negedge clk);
        i_switches = {2'b00, OpAdd};
        i_btn_op = 1'b1;
        @(posedge clk); #1;  // edge t
        @(posedge clk); #1;  // edge t+1: pulse now high, nothing loaded yet
        tests_run++;
        if (cod_operacion !== 6'd0 || o_estado !== 3'd2) begin
            tests_failed++;
            $display("FAIL op_latency_early: got op=%b st=%0d, want op=000000 st=2", cod_operacion, o_estado);
        end
        @(posedge clk); #1;  // edge t+2
        tests_run++;
        if (cod_operacion !== OpAdd || o_estado !== 3'd3 || o_result_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL op_load: got op=%b st=%0d v=%b, want op=100000 st=3 v=0",
                     cod_operacion, o_estado, o_result_valid);
        end
        @(posedge clk); #1;  // edge t+3
        tests_run++;
        if (o_result !== 8'h10 || o_result_valid !== 1'b1 || o_estado !== 3'd4) begin
            tests_failed++;
            $display("FAIL add_capture: got res=%h v=%b st=%0d, want res=10 v=1 st=4",
                     o_result, o_result_valid, o_estado);
        end
        @(negedge clk);
        i_btn_op = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_op_reload();
        int low_valid = 0;
        @(negedge clk);
        i_switches = {2'b00, OpSub};
        i_btn_op = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (o_result_valid !== 1'b1) low_valid++;
        end
        i_btn_op = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (o_result !== 8'hF8 || o_estado !== 3'd4 || low_valid !== 0) begin
            tests_failed++;
            $display("FAIL sub_reload: got res=%h st=%0d valid_low_cycles=%0d, want res=f8 st=4 0",
                     o_result, o_estado, low_valid);
        end
        press(0, 0, 1, {2'b00, OpAnd});
        tests_run++;
        if (o_result !== 8'h04 || o_result_valid !== 1'b1 || operando_A !== 8'h04 ||
            operando_B !== 8'h0C) begin
            tests_failed++;
            $display("FAIL and_reload: got res=%h v=%b A=%h B=%h, want res=04 v=1 A=04 B=0c",
                     o_result, o_result_valid, operando_A, operando_B);
        end
        press(0, 1, 0, 8'hEE);
        tests_run++;
        if (o_estado !== 3'd4 || operando_B !== 8'h0C) begin
            tests_failed++;
            $display("FAIL resultado_ignore_b: got st=%0d B=%h, want st=4 B=0c", o_estado, operando_B);
        end
    endtask

    task automatic test_ignore_wrong_buttons();
        do_reset();
        press(0, 1, 0, 8'h33);
        press(0, 0, 1, 8'h22);
        tests_run++;
        if (o_estado !== 3'd0 || operando_A !== 8'h00 || operando_B !== 8'h00 ||
            cod_operacion !== 6'd0) begin
            tests_failed++;
            $display("FAIL espera_a_ignore: got st=%0d A=%h B=%h op=%b, want 0 00 00 000000",
                     o_estado, operando_A, operando_B, cod_operacion);
        end
        press(1, 0, 0, 8'h0C);
        tests_run++;
        if (operando_A !== 8'h0C || o_estado !== 3'd1) begin
            tests_failed++;
            $display("FAIL espera_a_accept: got A=%h st=%0d, want A=0c st=1", operando_A, o_estado);
        end
    endtask

    task automatic test_hold();
        int changes = 0;
        logic [2:0] prev;
        do_reset();
        prev = o_estado;
        @(negedge clk);
        i_switches = 8'h55;
        i_btn_a = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (o_estado !== prev) changes++;
            prev = o_estado;
        end
        @(negedge clk);
        i_btn_a = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (changes !== 1 || o_estado !== 3'd1 || operando_A !== 8'h55) begin
            tests_failed++;
            $display("FAIL hold_one_pulse: got changes=%0d st=%0d A=%h, want 1 1 55",
                     changes, o_estado, operando_A);
        end
        press(1, 0, 0, 8'h77);
        tests_run++;
        if (o_estado !== 3'd1 || operando_A !== 8'h55) begin
            tests_failed++;
            $display("FAIL espera_b_ignore_a: got st=%0d A=%h, want st=1 A=55", o_estado, operando_A);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        press(1, 0, 0, 8'h12);
        press(0, 1, 0, 8'h34);
        press(0, 0, 1, {2'b00, OpAdd});
        press(1, 0, 0, 8'h12);
        press(0, 1, 0, 8'h34);
        tests_run++;
        if (o_estado !== 3'd2 || o_result !== 8'h46 || cod_operacion !== OpAdd) begin
            tests_failed++;
            $display("FAIL pre_reset_state: got st=%0d res=%h op=%b, want st=2 res=46 op=100000",
                     o_estado, o_result, cod_operacion);
        end
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        tests_run++;
        if ({operando_A, operando_B, cod_operacion, o_result, o_result_valid, o_estado} !== 34'd0) begin
            tests_failed++;
            $display("FAIL mid_reset: got A=%h B=%h op=%b res=%h v=%b st=%0d, want all 0",
                     operando_A, operando_B, cod_operacion, o_result, o_result_valid, o_estado);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        press(1, 0, 0, 8'h0F);
        press(0, 1, 0, 8'hF0);
        press(0, 0, 1, {2'b00, OpXor});
        tests_run++;
        if (o_result !== 8'hFF || o_estado !== 3'd4 || o_result_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL xor_result: got res=%h st=%0d v=%b, want res=ff st=4 v=1",
                     o_result, o_estado, o_result_valid);
        end
        press(1, 0, 1, 8'hA5);
        tests_run++;
        if (operando_A !== 8'hA5 || o_result_valid !== 1'b0 || o_estado !== 3'd1 ||
            cod_operacion !== OpXor || operando_B !== 8'hF0 || o_result !== 8'hFF) begin
            tests_failed++;
            $display("FAIL a_over_op: got A=%h v=%b st=%0d op=%b B=%h res=%h, want a5 0 1 100110 f0 ff",
                     operando_A, o_result_valid, o_estado, cod_operacion, operando_B, o_result);
        end
    endtask

    task automatic test_sra();
        press(0, 1, 0, 8'h02);
        press(0, 0, 1, {2'b00, OpSra});
        tests_run++;
        if (o_result !== 8'hE9 || o_result_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL sra_result: got res=%h v=%b, want res=e9 v=1", o_result, o_result_valid);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        i_switches = 8'h00;
        i_btn_a = 1'b0; i_btn_b = 1'b0; i_btn_op = 1'b0;
        test_reset();
        test_basic_add();
        test_op_reload();
        test_ignore_wrong_buttons();
        test_hold();
        test_reset_mid();
        test_simultaneous();
        test_sra();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
